// File: rtl/apb_timer_slave.sv
// apb_timer_slave: zero-wait-state APB completer wrapping a 32-bit down-counting timer with prescaler, auto-reload and maskable interrupt
module apb_timer_slave #(
  parameter int ADDR_W  = 8,
  parameter int PRESC_W = 16
) (
  input  logic              PCLK,
  input  logic              Prst,
  input  logic              PSEL,
  input  logic              Pen,
  input  logic              Pwrite,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic [31:0]       Pwdata,
  output logic [31:0]       Prdata,
  output logic              Irq
);
  logic en, auto_rl, irq_en, expired;
  logic en_n, auto_rl_n, irq_en_n, expired_n;
  logic [31:0] load, value, load_n, value_n, rdata;
  logic [PRESC_W-1:0] prescale, presc_cnt, prescale_n, presc_cnt_n;
  logic [ADDR_W-3:0] idx;
  logic wr, rd, w_ctrl, w_load, w_stat, w_presc, tick, expire;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Paddr[1:0];
  // address decode, next state with write-over-counter priority, and read mux
  always_comb begin
    idx         = Paddr[ADDR_W-1:2];
    wr          = PSEL & Pen & Pwrite;
    rd          = PSEL & !Pen & !Pwrite;
    w_ctrl      = wr & (idx == 0);
    w_load      = wr & (idx == 1);
    w_stat      = wr & (idx == 3);
    w_presc     = wr & (idx == 4);
    tick        = en & (presc_cnt >= prescale);
    expire      = tick & (value == 0);
    en_n        = w_ctrl ? Pwdata[0] : (expire & !auto_rl) ? 1'b0 : en;
    auto_rl_n   = w_ctrl ? Pwdata[1] : auto_rl;
    irq_en_n    = w_ctrl ? Pwdata[2] : irq_en;
    expired_n   = expire | (expired & !(w_stat & Pwdata[0]));
    load_n      = w_load ? Pwdata : load;
    prescale_n  = w_presc ? Pwdata[PRESC_W-1:0] : prescale;
    value_n     = w_load ? Pwdata : !tick ? value : (value != 0) ? value - 1 : auto_rl ? load : value;
    presc_cnt_n = (w_load | !en | !en_n | tick) ? '0 : presc_cnt + 1;
    rdata       = (idx == 0) ? {29'b0, irq_en, auto_rl, en} :
                  (idx == 1) ? load :
                  (idx == 2) ? value :
                  (idx == 3) ? {31'b0, expired} :
                  (idx == 4) ? 32'(prescale) : '0;
  end
  // state registers; read data captured at the end of Setup, Irq tracks next flag and enable
  always_ff @(posedge PCLK)
    if (Prst) begin
      en        <= 1'b0;
      auto_rl   <= 1'b0;
      irq_en    <= 1'b0;
      expired   <= 1'b0;
      load      <= '0;
      value     <= '0;
      prescale  <= '0;
      presc_cnt <= '0;
      Prdata    <= '0;
      Irq       <= 1'b0;
    end else begin
      en        <= en_n;
      auto_rl   <= auto_rl_n;
      irq_en    <= irq_en_n;
      expired   <= expired_n;
      load      <= load_n;
      value     <= value_n;
      prescale  <= prescale_n;
      presc_cnt <= presc_cnt_n;
      Prdata    <= rd ? rdata : Prdata;
      Irq       <= expired_n & irq_en_n;
    end
endmodule
